// File: rtl/mastermind_game_ctrl.sv
// ---------------------------------------------------------------------------
// mastermind_game_ctrl
//
// Game-control stage that sits in front of the VGA peg renderer. It owns the
// 6x4 guess board, the secret code, the cursor and the per-row feedback. It
// turns single-cycle button pulses into board edits, and scores a submitted
// row over ten cycles: four exact-match steps, then six per-colour steps.
//
// Optional build macro:
//   MM_DEBUG_SECRET_EN  when defined, secret_out shows the secret register;
//                       when undefined, secret_out is tied to zero. Scoring
//                       is the same either way.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   btn_start    pulse: new game (INPUT, WIN, LOSE)
//   btn_left     pulse: cursor left, wraps 0 -> 3
//   btn_right    pulse: cursor right, wraps 3 -> 0
//   btn_up       pulse: step colour at the cursor, 6 wraps to 1
//   btn_center   pulse: submit the current row when all four cells are set
//   matrix_flat  board; row r at [r*12 +: 12], column c at [c*3 +: 3]
//   fb_flat      feedback; row r at [r*6 +: 6] = {partial, exact}
//   guess_num    current attempt 0..5
//   cursor       selected column 0..3
//   q_Init .. q_Lose  one-hot state flags
//   secret_out   secret code, packed like a board row
// ---------------------------------------------------------------------------
module mastermind_game_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_GUESS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_center,
  output logic [71:0] matrix_flat,
  output logic [35:0] fb_flat,
  output logic [2:0]  guess_num,
  output logic [1:0]  cursor,
  output logic        q_Init,
  output logic        q_Input,
  output logic        q_Check,
  output logic        q_Win,
  output logic        q_Lose,
  output logic [11:0] secret_out
);

  // The state register is one-hot so every q_* flag is a flop output.
  localparam logic [4:0] S_INIT  = 5'b00001;
  localparam logic [4:0] S_INPUT = 5'b00010;
  localparam logic [4:0] S_CHECK = 5'b00100;
  localparam logic [4:0] S_WIN   = 5'b01000;
  localparam logic [4:0] S_LOSE  = 5'b10000;

  localparam logic [2:0] LAST_GUESS = 3'(MAX_GUESS - 1);
  localparam logic [3:0] LAST_STEP  = 4'd9;

  logic [4:0]  state;
  logic [15:0] lfsr;
  logic [11:0] secret;
  logic [3:0]  step;
  logic [2:0]  exact_acc;
  logic [2:0]  total_acc;

  logic [6:0]  row_base;
  logic [6:0]  cell_base;
  logic [5:0]  fb_base;
  logic [3:0]  col_base;
  logic [11:0] cur_row;
  logic [2:0]  cur_cell;
  logic [2:0]  cell_next;
  logic        row_full;
  logic [2:0]  guess_col;
  logic [2:0]  secret_col;
  logic [2:0]  colour;
  logic [2:0]  cnt_guess;
  logic [2:0]  cnt_secret;
  logic [2:0]  min_cnt;
  logic [2:0]  exact_next;
  logic [2:0]  total_next;
  logic [11:0] new_secret;

  assign q_Init  = state[0];
  assign q_Input = state[1];
  assign q_Check = state[2];
  assign q_Win   = state[3];
  assign q_Lose  = state[4];

`ifdef MM_DEBUG_SECRET_EN
  assign secret_out = secret;
`else
  assign secret_out = 12'h000;
`endif

  // Maps a random nibble onto a peg colour 1..6.
  function automatic logic [2:0] mod6p1(input logic [3:0] n);
    logic [3:0] r;
    r = n % 4'd6;
    return r[2:0] + 3'd1;
  endfunction

  // Free-running pseudo-random source. It keeps shifting in every state so
  // the secret depends on how long the player waited before pressing start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Datapath decode: addresses of the active row, cell and feedback slot,
  // the next colour for an up press, and the per-step scoring terms. During
  // CHECK, steps 0..3 compare one column each and steps 4..9 handle colours
  // 1..6 with a popcount over the four columns of guess and secret.
  always_comb begin
    row_base   = 7'(guess_num) * 7'd12;
    cell_base  = row_base + 7'({cursor, 1'b0}) + 7'(cursor);
    fb_base    = 6'(guess_num) * 6'd6;
    col_base   = 4'({step[1:0], 1'b0}) + 4'(step[1:0]);
    cur_row    = matrix_flat[row_base +: 12];
    cur_cell   = matrix_flat[cell_base +: 3];
    cell_next  = (cur_cell == 3'd6) ? 3'd1 : cur_cell + 3'd1;
    row_full   = (cur_row[2:0] != 3'd0) && (cur_row[5:3] != 3'd0) &&
                 (cur_row[8:6] != 3'd0) && (cur_row[11:9] != 3'd0);
    guess_col  = cur_row[col_base +: 3];
    secret_col = secret[col_base +: 3];
    colour     = 3'(step - 4'd3);
    cnt_guess  = 3'd0;
    cnt_secret = 3'd0;
    new_secret = 12'h000;
    for (int c = 0; c < 4; c++) begin
      if (cur_row[c*3 +: 3] == colour) cnt_guess = cnt_guess + 3'd1;
      if (secret[c*3 +: 3] == colour) cnt_secret = cnt_secret + 3'd1;
      new_secret[c*3 +: 3] = mod6p1(lfsr[c*4 +: 4]);
    end
    min_cnt = (cnt_guess < cnt_secret) ? cnt_guess : cnt_secret;
    if (step < 4'd4) begin
      exact_next = exact_acc + {2'b00, (guess_col == secret_col)};
      total_next = total_acc;
    end else begin
      exact_next = exact_acc;
      total_next = total_acc + min_cnt;
    end
  end

  // Game state machine. Reset wins over everything, including a check in
  // progress. In INPUT only the highest-priority button acts; a rejected
  // submit swallows the cycle rather than falling through to a lower button.
  // The feedback row is written on the last CHECK step using that step's
  // accumulated totals, so partial = total - exact never underflows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_INIT;
      matrix_flat <= '0;
      fb_flat     <= '0;
      guess_num   <= '0;
      cursor      <= '0;
      secret      <= '0;
      step        <= '0;
      exact_acc   <= '0;
      total_acc   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          matrix_flat <= '0;
          fb_flat     <= '0;
          guess_num   <= '0;
          cursor      <= '0;
          secret      <= new_secret;
          step        <= '0;
          exact_acc   <= '0;
          total_acc   <= '0;
          state       <= S_INPUT;
        end
        S_INPUT: begin
          if (btn_start) begin
            state <= S_INIT;
          end else if (btn_center) begin
            if (row_full) begin
              state     <= S_CHECK;
              step      <= '0;
              exact_acc <= '0;
              total_acc <= '0;
            end
          end else if (btn_up) begin
            matrix_flat[cell_base +: 3] <= cell_next;
          end else if (btn_right) begin
            cursor <= cursor + 2'd1;
          end else if (btn_left) begin
            cursor <= cursor - 2'd1;
          end
        end
        S_CHECK: begin
          step      <= step + 4'd1;
          exact_acc <= exact_next;
          total_acc <= total_next;
          if (step == LAST_STEP) begin
            fb_flat[fb_base +: 6] <= {total_next - exact_next, exact_next};
            if (exact_next == 3'd4) begin
              state <= S_WIN;
            end else if (guess_num == LAST_GUESS) begin
              state <= S_LOSE;
            end else begin
              guess_num <= guess_num + 3'd1;
              cursor    <= '0;
              state     <= S_INPUT;
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (btn_start) state <= S_INIT;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mastermind_game_ctrl
//
// Scoreboard bench for mastermind_game_ctrl. Stimulus tasks keep a small
// model of the board and push the expected output snapshot for each button
// pulse; a negedge monitor pops snapshots when they come due and also pops a
// score record each time q_Check falls. The secret is predicted from an
// independent model of the LFSR, so the bench works with or without
// MM_DEBUG_SECRET_EN.
// ---------------------------------------------------------------------------
module tb_mastermind_game_ctrl;

  localparam logic [4:0] F_INIT  = 5'b00001;
  localparam logic [4:0] F_INPUT = 5'b00010;
  localparam logic [4:0] F_CHECK = 5'b00100;
  localparam logic [4:0] F_WIN   = 5'b01000;
  localparam logic [4:0] F_LOSE  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start, btn_left, btn_right, btn_up, btn_center;
  logic [71:0] matrix_flat;
  logic [35:0] fb_flat;
  logic [2:0]  guess_num;
  logic [1:0]  cursor;
  logic        q_Init, q_Input, q_Check, q_Win, q_Lose;
  logic [11:0] secret_out;

  typedef struct {
    int          due;
    string       name;
    logic [4:0]  flags;
    logic [2:0]  gn;
    logic [1:0]  cur;
    logic [71:0] mat;
    logic [35:0] fb;
    logic [11:0] sec;
  } snap_t;

  typedef struct {
    string       name;
    int          len;
    logic [4:0]  flags;
    logic [2:0]  gn;
    logic [1:0]  cur;
    logic [71:0] mat;
    logic [35:0] fb;
  } score_t;

  snap_t  snap_q[$];
  score_t score_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [15:0] lfsr_m;
  logic [4:0]  m_flags;
  logic [2:0]  m_gn;
  logic [1:0]  m_cur;
  logic [71:0] m_mat;
  logic [35:0] m_fb;
  logic [11:0] m_secret;

  mastermind_game_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_center  (btn_center),
    .matrix_flat (matrix_flat),
    .fb_flat     (fb_flat),
    .guess_num   (guess_num),
    .cursor      (cursor),
    .q_Init      (q_Init),
    .q_Input     (q_Input),
    .q_Check     (q_Check),
    .q_Win       (q_Win),
    .q_Lose      (q_Lose),
    .secret_out  (secret_out)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to tag when each expected snapshot becomes visible.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: taps 16,14,13,11 expressed as a parity mask.
  always @(posedge clk) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation ran out of time, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  function automatic logic [2:0] alt(input logic [2:0] v);
    return (v == 3'd6) ? 3'd1 : v + 3'd1;
  endfunction

  function automatic logic [11:0] mkRow(input logic [2:0] c0, input logic [2:0] c1,
                                        input logic [2:0] c2, input logic [2:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [11:0] secretFrom(input logic [15:0] l);
    logic [11:0] s;
    int v;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      v = int'(l[c*4 +: 4]);
      s[c*3 +: 3] = 3'((v % 6) + 1);
    end
    return s;
  endfunction

  // Classic peg-marking score: {partial, exact}.
  function automatic logic [5:0] score(input logic [11:0] g, input logic [11:0] s);
    int ex, part;
    bit used_g[4];
    bit used_s[4];
    ex = 0;
    part = 0;
    for (int i = 0; i < 4; i++) begin
      used_g[i] = 1'b0;
      used_s[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (g[i*3 +: 3] == s[i*3 +: 3]) begin
        ex++;
        used_g[i] = 1'b1;
        used_s[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!used_g[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!used_s[j] && g[i*3 +: 3] == s[j*3 +: 3]) begin
            used_s[j] = 1'b1;
            part++;
            break;
          end
        end
      end
    end
    return {3'(part), 3'(ex)};
  endfunction

  function automatic logic [2:0] modelCell(input int c);
    return m_mat[int'(m_gn)*12 + c*3 +: 3];
  endfunction

  task automatic pushSnap(input string name);
    snap_t s;
    s.due   = cyc + 1;
    s.name  = name;
    s.flags = m_flags;
    s.gn    = m_gn;
    s.cur   = m_cur;
    s.mat   = m_mat;
    s.fb    = m_fb;
`ifdef MM_DEBUG_SECRET_EN
    s.sec   = m_secret;
`else
    s.sec   = 12'h000;
`endif
    snap_q.push_back(s);
  endtask

  task automatic pushScore(input string name, input int len);
    score_t e;
    e.name  = name;
    e.len   = len;
    e.flags = m_flags;
    e.gn    = m_gn;
    e.cur   = m_cur;
    e.mat   = m_mat;
    e.fb    = m_fb;
    score_q.push_back(e);
  endtask

  task automatic pulse(input logic s, input logic c, input logic u, input logic r, input logic l);
    btn_start = s; btn_center = c; btn_up = u; btn_right = r; btn_left = l;
    @(posedge clk); #1;
    btn_start = 0; btn_center = 0; btn_up = 0; btn_right = 0; btn_left = 0;
  endtask

  // The INIT cycle: latches the secret from the current LFSR value.
  task automatic doInit(input string name);
    m_secret = secretFrom(lfsr_m);
    m_mat = '0; m_fb = '0; m_gn = '0; m_cur = '0;
    m_flags = F_INPUT;
    pushSnap(name);
    @(posedge clk); #1;
  endtask

  // Issues one button pattern and records what the DUT should show next.
  task automatic applyStimulus(input string name, input logic s, input logic c,
                               input logic u, input logic r, input logic l);
    logic [5:0] sc;
    bit go_init, go_check;
    go_init = 0;
    go_check = 0;
    if (m_flags == F_INPUT) begin
      if (s) begin
        m_flags = F_INIT; go_init = 1;
      end else if (c) begin
        if (modelCell(0) != 0 && modelCell(1) != 0 && modelCell(2) != 0 && modelCell(3) != 0) begin
          m_flags = F_CHECK; go_check = 1;
        end
      end else if (u) begin
        m_mat[int'(m_gn)*12 + int'(m_cur)*3 +: 3] = 3'((int'(modelCell(int'(m_cur))) % 6) + 1);
      end else if (r) begin
        m_cur = m_cur + 2'd1;
      end else if (l) begin
        m_cur = m_cur - 2'd1;
      end
    end else if (m_flags == F_WIN || m_flags == F_LOSE) begin
      if (s) begin
        m_flags = F_INIT; go_init = 1;
      end
    end
    pushSnap(name);
    pulse(s, c, u, r, l);
    if (go_init) doInit({name, "_init"});
    if (go_check) begin
      sc = score(m_mat[int'(m_gn)*12 +: 12], m_secret);
      m_fb[int'(m_gn)*6 +: 6] = sc;
      if (sc[2:0] == 3'd4) m_flags = F_WIN;
      else if (m_gn == 3'd5) m_flags = F_LOSE;
      else begin
        m_gn = m_gn + 3'd1; m_cur = 2'd0; m_flags = F_INPUT;
      end
      pushScore({name, "_score"}, 10);
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  // Steers the cursor and colours until the current row equals g.
  task automatic setRow(input string name, input logic [11:0] g, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      for (int k = 0; k < 4 && int'(m_cur) != c; k++) applyStimulus({name, "_right"}, 0, 0, 0, 1, 0);
      for (int k = 0; k < 7 && modelCell(c) != g[c*3 +: 3]; k++) applyStimulus({name, "_up"}, 0, 0, 1, 0, 0);
    end
  endtask

  // Monitor: compares due snapshots, and on each falling edge of q_Check
  // compares the check length and the post-check outputs.
  int   chk_len = 0;
  logic prev_check = 1'b0;
  always @(negedge clk) begin
    snap_t  s;
    score_t e;
    while (snap_q.size() > 0 && snap_q[0].due <= cyc) begin
      s = snap_q.pop_front();
      checkOutput({s.name, ".flags"}, {q_Lose, q_Win, q_Check, q_Input, q_Init}, s.flags);
      checkOutput({s.name, ".guess_num"}, guess_num, s.gn);
      checkOutput({s.name, ".cursor"}, cursor, s.cur);
      checkOutput({s.name, ".matrix"}, matrix_flat, s.mat);
      checkOutput({s.name, ".fb"}, fb_flat, s.fb);
      checkOutput({s.name, ".secret_out"}, secret_out, s.sec);
    end
    if (q_Check === 1'b1) begin
      chk_len++;
    end else if (prev_check === 1'b1) begin
      if (score_q.size() == 0) begin
        checkOutput("unexpected_check_end", 72'd1, 72'd0);
      end else begin
        e = score_q.pop_front();
        checkOutput({e.name, ".check_cycles"}, 72'(chk_len), 72'(e.len));
        checkOutput({e.name, ".flags"}, {q_Lose, q_Win, q_Check, q_Input, q_Init}, e.flags);
        checkOutput({e.name, ".guess_num"}, guess_num, e.gn);
        checkOutput({e.name, ".cursor"}, cursor, e.cur);
        checkOutput({e.name, ".matrix"}, matrix_flat, e.mat);
        checkOutput({e.name, ".fb"}, fb_flat, e.fb);
      end
      chk_len = 0;
    end
    prev_check = q_Check;
  end

  // Directed scenario sequence.
  initial begin
    logic [2:0] s0, s1, s2, s3;
    rst_n = 0;
    btn_start = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_center = 0;
    m_flags = F_INIT; m_gn = '0; m_cur = '0; m_mat = '0; m_fb = '0; m_secret = '0;
    repeat (2) @(posedge clk);
    #1;
    pushSnap("reset_state");
    @(posedge clk); #1;
    rst_n = 1;
    doInit("post_reset_init");

    applyStimulus("start", 1, 0, 0, 0, 0);

    // Cursor wrap and colour cycling in column 3.
    applyStimulus("left_wrap", 0, 0, 0, 0, 1);
    repeat (3) applyStimulus("up_to3", 0, 0, 1, 0, 0);
    repeat (7) applyStimulus("up_wrap_to4", 0, 0, 1, 0, 0);
    applyStimulus("up_and_right", 0, 0, 1, 1, 0);
    applyStimulus("right_wrap", 0, 0, 0, 1, 0);

    // Column 2 still empty: submit must be ignored.
    setRow("partial", mkRow(3'd1, 3'd1, 3'd0, 3'd0), 2);
    applyStimulus("center_ignored", 0, 1, 0, 0, 0);

    // Winning game: three wrong guesses then the secret on attempt 3.
    s0 = m_secret[2:0]; s1 = m_secret[5:3]; s2 = m_secret[8:6]; s3 = m_secret[11:9];
    setRow("g0", mkRow(alt(s0), s0, s3, s2), 4);
    applyStimulus("submit0", 0, 1, 0, 0, 0);
    setRow("g1", mkRow(alt(s0), s1, s2, s3), 4);
    applyStimulus("submit1", 0, 1, 0, 0, 0);
    setRow("g2", mkRow(alt(s0), alt(s1), 3'd1, 3'd6), 4);
    applyStimulus("submit2", 0, 1, 0, 0, 0);
    setRow("g3", m_secret, 4);
    applyStimulus("submit3_win", 0, 1, 0, 0, 0);
    applyStimulus("win_up_ignored", 0, 0, 1, 0, 0);
    applyStimulus("win_center_ignored", 0, 1, 0, 0, 0);
    applyStimulus("win_start", 1, 0, 0, 0, 0);

    // Losing game: six guesses, each wrong in column 0.
    s0 = m_secret[2:0]; s2 = m_secret[8:6];
    for (int i = 0; i < 6; i++) begin
      setRow("lose_row", mkRow(alt(s0), 3'((i % 6) + 1), s2, 3'(((i + 2) % 6) + 1)), 4);
      applyStimulus("lose_submit", 0, 1, 0, 0, 0);
    end
    applyStimulus("lose_left_ignored", 0, 0, 0, 0, 1);
    applyStimulus("lose_start", 1, 0, 0, 0, 0);

    // Reset while a check is in progress.
    setRow("rc", mkRow(3'd2, 3'd3, 3'd4, 3'd5), 4);
    m_flags = F_CHECK;
    pushSnap("center_before_reset");
    pulse(0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    m_flags = F_INIT; m_gn = '0; m_cur = '0; m_mat = '0; m_fb = '0; m_secret = '0;
    pushScore("check_cut_by_reset", 4);
    pushSnap("reset_mid_check");
    @(posedge clk); #1;
    rst_n = 1;
    doInit("post_mid_reset_init");
    applyStimulus("after_reset_left", 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("snap_queue_drained", 72'(snap_q.size()), 72'd0);
    checkOutput("score_queue_drained", 72'(score_q.size()), 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
